// File: rtl/vending_pkg.sv
// Shared coin codes and coin-acceptor state encodings, used by the acceptor
// and by the downstream vending FSM.
package vending_pkg;

    localparam logic [1:0] COIN_IDLE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        CA_IDLE = 2'b00,
        CA_MEAS = 2'b01,
        CA_JAM  = 2'b10,
        CA_HOLD = 2'b11
    } ca_state_t;

    function automatic logic in_band(input int w, input int lo, input int hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a raw asynchronous input; both flops clear on
// synchronous active-low reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin classifier: measures synchronized sensor pulse width and emits one
// registered coin code or reject per physical coin, with jam detection.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int W5_MIN    = 4,
    parameter int W5_MAX    = 7,
    parameter int W10_MIN   = 10,
    parameter int W10_MAX   = 15,
    parameter int JAM_LIMIT = 31,
    parameter int GAP       = 3,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense,
    input  logic       enable,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam,
    output logic [1:0] state_present
);

    localparam logic [CNT_W-1:0] L_ZERO = '0;
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_JAM  = CNT_W'(JAM_LIMIT);
    localparam logic [CNT_W-1:0] L_GAP  = CNT_W'(GAP);

    logic             w_s_sync;
    ca_state_t        r_state;
    ca_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_coin;
    logic [1:0]       w_coin_nxt;
    logic             r_reject;
    logic             w_rej_nxt;
    logic             r_jam;
    logic [CNT_W-1:0] w_cnt_inc;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (sense),
        .o_q (w_s_sync)
    );

    assign w_cnt_inc = r_cnt + L_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_coin_nxt  = COIN_IDLE;
        w_rej_nxt   = 1'b0;
        case (r_state)
            CA_IDLE: begin
                if (w_s_sync) begin
                    w_state_nxt = CA_MEAS;
                    w_cnt_nxt   = L_ONE;
                end
            end
            CA_MEAS: begin
                if (w_s_sync) begin
                    if (r_cnt == L_JAM) w_state_nxt = CA_JAM;
                    else                w_cnt_nxt   = w_cnt_inc;
                end else begin
                    // Falling edge: enable only matters on this cycle.
                    w_state_nxt = CA_HOLD;
                    w_cnt_nxt   = L_ZERO;
                    if (enable && in_band(int'(r_cnt), W5_MIN, W5_MAX))
                        w_coin_nxt = COIN_5;
                    else if (enable && in_band(int'(r_cnt), W10_MIN, W10_MAX))
                        w_coin_nxt = COIN_10;
                    else
                        w_rej_nxt = 1'b1;
                end
            end
            CA_JAM: begin
                if (!w_s_sync) begin
                    w_state_nxt = CA_HOLD;
                    w_cnt_nxt   = L_ZERO;
                    w_rej_nxt   = 1'b1;
                end
            end
            CA_HOLD: begin
                // Any high here is trailing bounce; it restarts the quiet gap.
                if (w_s_sync) begin
                    w_cnt_nxt = L_ZERO;
                end else if (w_cnt_inc == L_GAP) begin
                    w_state_nxt = CA_IDLE;
                    w_cnt_nxt   = L_ZERO;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = CA_HOLD;
                w_cnt_nxt   = L_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= CA_HOLD;
            r_cnt    <= L_ZERO;
            r_coin   <= COIN_IDLE;
            r_reject <= 1'b0;
            r_jam    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_coin   <= w_coin_nxt;
            r_reject <= w_rej_nxt;
            r_jam    <= (w_state_nxt == CA_JAM);
        end
    end

    assign coin          = r_coin;
    assign reject        = r_reject;
    assign jam           = r_jam;
    assign state_present = r_state;

endmodule
